// File: rtl/mips_enc_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic codes,
// opcode/funct constants, FSM states and word-format helpers.
package mips_enc_pkg;

  typedef enum logic [5:0] {
    MN_ADD  = 6'd0,  MN_ADDU = 6'd1,  MN_SUB  = 6'd2,  MN_SUBU = 6'd3,
    MN_AND  = 6'd4,  MN_OR   = 6'd5,  MN_NOR  = 6'd6,  MN_XOR  = 6'd7,
    MN_SLT  = 6'd8,  MN_SLTU = 6'd9,  MN_SLL  = 6'd10, MN_SRL  = 6'd11,
    MN_SRA  = 6'd12, MN_SLLV = 6'd13, MN_SRLV = 6'd14, MN_SRAV = 6'd15,
    MN_JR   = 6'd16, MN_JALR = 6'd17,
    MN_ADDI = 6'd18, MN_ANDI = 6'd19, MN_ORI  = 6'd20, MN_SLTI = 6'd21,
    MN_LUI  = 6'd22, MN_LW   = 6'd23, MN_LB   = 6'd24, MN_LH   = 6'd25,
    MN_LBU  = 6'd26, MN_LHU  = 6'd27, MN_SW   = 6'd28, MN_SB   = 6'd29,
    MN_SH   = 6'd30, MN_BEQ  = 6'd31, MN_BNE  = 6'd32,
    MN_J    = 6'd33, MN_JAL  = 6'd34
  } mnem_e;

  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_LUI  = 6'b001111, OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000, OP_LH   = 6'b100001, OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101, OP_SW   = 6'b101011, OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010, OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000, FN_ADDU = 6'b100001, FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011, FN_AND  = 6'b100100, FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111, FN_XOR  = 6'b100110, FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011, FN_SLL  = 6'b000000, FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011, FN_SLLV = 6'b000100, FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111, FN_JR   = 6'b001000, FN_JALR = 6'b001001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] shamt, logic [5:0] funct);
    return {6'b000000, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(logic [5:0] op, logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: mnemonic plus operand fields to a 32-bit MIPS word,
// applying the per-mnemonic field forcing and flagging unknown mnemonics.
module mips_word_pack
  import mips_enc_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      MN_ADDU: word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      MN_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      MN_SUBU: word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      MN_AND:  word = r_word(rs, rt, rd, 5'd0, FN_AND);
      MN_OR:   word = r_word(rs, rt, rd, 5'd0, FN_OR);
      MN_NOR:  word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      MN_XOR:  word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      MN_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      MN_SLTU: word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      MN_SLLV: word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      MN_SRLV: word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      MN_SRAV: word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      // Immediate shifts carry the amount in shamt; rs has no meaning.
      MN_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      MN_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      MN_SRA:  word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      MN_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_JALR: word = r_word(rs, 5'd0, (rd == 5'd0) ? 5'd31 : rd, 5'd0, FN_JALR);
      MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      MN_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      MN_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      MN_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      MN_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
      MN_LW:   word = i_word(OP_LW, rs, rt, imm);
      MN_LB:   word = i_word(OP_LB, rs, rt, imm);
      MN_LH:   word = i_word(OP_LH, rs, rt, imm);
      MN_LBU:  word = i_word(OP_LBU, rs, rt, imm);
      MN_LHU:  word = i_word(OP_LHU, rs, rt, imm);
      MN_SW:   word = i_word(OP_SW, rs, rt, imm);
      MN_SB:   word = i_word(OP_SB, rs, rt, imm);
      MN_SH:   word = i_word(OP_SH, rs, rt, imm);
      MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:  word = i_word(OP_BNE, rs, rt, imm);
      MN_J:    word = j_word(OP_J, target);
      MN_JAL:  word = j_word(OP_JAL, target);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder / instruction-memory loader: one registered output
// stage feeding the memory write port at an auto-incrementing byte address.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

  state_e      state, state_nxt;
  logic        accept, write, start_ok;
  logic [31:0] pack_word;
  logic        pack_illegal;

  mips_word_pack u_pack (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign accept   = in_valid & in_ready;
  assign write    = im_we & im_ready;
  assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      // An illegal final beat has nothing to write, so skip DRAIN.
      ST_RUN:   if (accept && in_last) state_nxt = pack_illegal ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (write) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_RUN) || (state == ST_DRAIN);
    in_ready = (state == ST_RUN) && (!im_we || im_ready);
  end

  // im_we doubles as the output-register full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we    <= 1'b0;
      im_wdata <= '0;
      im_addr  <= BASE_ADDR;
      word_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (start_ok) begin
        im_addr  <= start_addr & ~ADDR_W'(3);
        word_cnt <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
      end else begin
        if (write) begin
          im_addr <= im_addr + ADDR_W'(4);
          if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        end
        if (accept && pack_illegal) err <= 1'b1;
        if ((state != ST_DONE) && (state_nxt == ST_DONE)) done <= 1'b1;
      end

      if (accept && !pack_illegal) begin
        im_we    <= 1'b1;
        im_wdata <= pack_word;
      end else if (write) begin
        im_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed program steps plus a
// randomized program checked against an arithmetic encoding model and write scoreboard.
module tb_mips_instr_encoder;
  import mips_enc_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [5:0]  in_mnem = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        im_we, im_ready;
  logic [31:0] im_addr, im_wdata;
  logic        busy, done, err;
  logic [15:0] word_cnt;

  logic ready_mode = 1'b0, ready_force = 1'b1, rnd_bit = 1'b1;
  assign im_ready = ready_mode ? rnd_bit : ready_force;

  mips_instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    rnd_bit = 1'($urandom);
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [31:0] addr; logic [31:0] word; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] exp_addr = BASE;
  int          n_legal = 0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the instruction-set tables: {illegal, word}.
  function automatic logic [32:0] model_enc(input logic [5:0] m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tgt);
    longint fn = -1, op = -1;
    longint rsv = longint'(rs), rtv = longint'(rt), rdv = longint'(rd), shv = 0;
    case (m)
      MN_ADD:  fn = 32;  MN_ADDU: fn = 33;  MN_SUB:  fn = 34;  MN_SUBU: fn = 35;
      MN_AND:  fn = 36;  MN_OR:   fn = 37;  MN_NOR:  fn = 39;  MN_XOR:  fn = 38;
      MN_SLT:  fn = 42;  MN_SLTU: fn = 43;  MN_SLLV: fn = 4;   MN_SRLV: fn = 6;
      MN_SRAV: fn = 7;
      MN_SLL:  begin fn = 0; rsv = 0; shv = longint'(sh); end
      MN_SRL:  begin fn = 2; rsv = 0; shv = longint'(sh); end
      MN_SRA:  begin fn = 3; rsv = 0; shv = longint'(sh); end
      MN_JR:   begin fn = 8; rtv = 0; rdv = 0; end
      MN_JALR: begin fn = 9; rtv = 0; rdv = (rd == 0) ? 31 : longint'(rd); end
      MN_ADDI: op = 8;   MN_ANDI: op = 12;  MN_ORI:  op = 13;  MN_SLTI: op = 10;
      MN_LUI:  begin op = 15; rsv = 0; end
      MN_LW:   op = 35;  MN_LB:   op = 32;  MN_LH:   op = 33;  MN_LBU:  op = 36;
      MN_LHU:  op = 37;  MN_SW:   op = 43;  MN_SB:   op = 40;  MN_SH:   op = 41;
      MN_BEQ:  op = 4;   MN_BNE:  op = 5;   MN_J:    op = 2;   MN_JAL:  op = 3;
      default: ;
    endcase
    if (m == MN_J || m == MN_JAL) return {1'b0, 32'(op * 64'd67108864 + longint'(tgt))};
    if (fn >= 0) return {1'b0, 32'(rsv * 2097152 + rtv * 65536 + rdv * 2048 + shv * 64 + fn)};
    if (op >= 0) return {1'b0, 32'(op * 64'd67108864 + rsv * 2097152 + rtv * 65536 + longint'(imm))};
    return {1'b1, 32'h0};
  endfunction

  // Records the expected effect of a beat accepted at the coming edge.
  task automatic model_accept(input logic [32:0] r);
    if (!r[32]) begin
      exp_q.push_back('{addr: exp_addr, word: r[31:0]});
      exp_addr = exp_addr + 32'd4;
      n_legal++;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && im_we && im_ready) begin
      wr_t e;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", im_addr, e.addr);
        check("wr_data", im_wdata, e.word);
      end
    end
  end

  task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
      input logic [25:0] tgt, input logic last);
    int waited = 0;
    in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_last = last;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_budget", 32'(in_ready), 32'd1);
    if (in_ready) model_accept(model_enc(m, rs, rt, rd, sh, imm, tgt));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_addr = a & ~32'd3;
    n_legal = 0;
    exp_err = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr", 32'(err), 32'd0);
    check("start_cnt_clr", 32'(word_cnt), 32'd0);
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("done_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] legal [35] = '{MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_NOR,
    MN_XOR, MN_SLT, MN_SLTU, MN_SLL, MN_SRL, MN_SRA, MN_SLLV, MN_SRLV, MN_SRAV, MN_JR,
    MN_JALR, MN_ADDI, MN_ANDI, MN_ORI, MN_SLTI, MN_LUI, MN_LW, MN_LB, MN_LH, MN_LBU,
    MN_LHU, MN_SW, MN_SB, MN_SH, MN_BEQ, MN_BNE, MN_J, MN_JAL};

  initial begin
    logic [32:0] r;
    // Reset values, checked while reset is held and after release.
    #12;
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", im_addr, BASE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_im_we", 32'(im_we), 32'd0);
    check("idle_im_addr", im_addr, BASE);
    check("idle_im_wdata", im_wdata, 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("idle_cnt", 32'(word_cnt), 32'd0);

    // Directed program: back-to-back add/addi, start ignored in RUN, sll/lw, then j last.
    do_start(32'h0000_3000);
    send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
    check("add_word", im_wdata, 32'h0022_1820);
    send(MN_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0);
    check("addi_word", im_wdata, 32'h2008_0005);
    check("addi_addr", im_addr, 32'h0000_3004);
    start = 1'b1; start_addr = 32'h0000_9000;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ignored_cnt", 32'(word_cnt), 32'd2);
    check("start_ignored_busy", 32'(busy), 32'd1);
    send(MN_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0);
    check("sll_word", im_wdata, 32'h0001_1100);
    send(MN_LW, 5'd8, 5'd9, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
    check("lw_word", im_wdata, 32'h8D09_0004);
    send(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100, 1'b1);
    check("j_word", im_wdata, 32'h0800_0100);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    check("drain_done_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("done_set", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("done_cnt", 32'(word_cnt), 32'd5);
    check("done_q_empty", 32'(exp_q.size()), 32'd0);

    // Stall: memory holds off for five cycles, then a release writes and accepts together.
    do_start(32'h0000_3000);
    ready_force = 1'b0;
    send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
    in_valid = 1'b1; in_mnem = MN_SUB; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
    in_shamt = 5'd9; in_imm = '0; in_target = '0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_we", 32'(im_we), 32'd1);
      check("stall_addr", im_addr, 32'h0000_3000);
      check("stall_wdata", im_wdata, 32'h0022_1820);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    ready_force = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    model_accept(model_enc(MN_SUB, 5'd4, 5'd5, 5'd6, 5'd9, 16'd0, 26'd0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_next_we", 32'(im_we), 32'd1);
    check("release_next_addr", im_addr, 32'h0000_3004);
    check("release_next_word", im_wdata, 32'h0085_3022);
    send(MN_JR, 5'd31, 5'd3, 5'd3, 5'd3, 16'd0, 26'd0, 1'b1);
    wait_done();
    check("stall_cnt", 32'(word_cnt), 32'd3);

    // Illegal mnemonic between legal beats, then an illegal final beat.
    do_start(32'h0000_3000);
    send(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
    send(6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'd0, 1'b0);
    check("illegal_err", 32'(err), 32'd1);
    send(MN_ORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'd0, 1'b0);
    send(MN_BEQ, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b1);
    wait_done();
    check("illegal_cnt", 32'(word_cnt), 32'd3);
    check("illegal_err_sticky", 32'(err), 32'd1);
    do_start(32'h0000_4000);
    send(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    check("illegal_last_done", 32'(done), 32'd1);
    check("illegal_last_busy", 32'(busy), 32'd0);
    check("illegal_last_cnt", 32'(word_cnt), 32'd0);
    check("illegal_last_we", 32'(im_we), 32'd0);

    // Reset while a write is pending.
    do_start(32'h0000_5003);
    ready_force = 1'b0;
    send(MN_LUI, 5'd9, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0);
    check("pre_rst_we", 32'(im_we), 32'd1);
    check("pre_rst_addr", im_addr, 32'h0000_5000);
    check("lui_word", im_wdata, 32'h3C04_1234);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_we", 32'(im_we), 32'd0);
    check("async_rst_addr", im_addr, BASE);
    check("async_rst_wdata", im_wdata, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_force = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd0);
    check("post_rst_addr", im_addr, BASE);
    check("post_rst_cnt", 32'(word_cnt), 32'd0);

    // Randomized program with random memory back-pressure, starting near address wrap.
    ready_mode = 1'b1;
    do_start(32'hFFFF_FFF6);
    for (int i = 0; i < 60; i++) begin
      logic [5:0] m;
      if (i != 59 && $urandom_range(0, 9) == 0) m = 6'($urandom_range(48, 63));
      else m = legal[$urandom_range(0, 34)];
      send(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), 1'(i == 59));
    end
    wait_done();
    check("rand_cnt", 32'(word_cnt), 32'(n_legal));
    check("rand_err", 32'(err), 32'(exp_err));
    check("rand_busy", 32'(busy), 32'd0);
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);
    r = model_enc(MN_JALR, 5'd2, 5'd7, 5'd0, 5'd3, 16'd0, 26'd0);
    ready_mode = 1'b0;
    do_start(32'h0000_3000);
    send(MN_JALR, 5'd2, 5'd7, 5'd0, 5'd3, 16'd0, 26'd0, 1'b1);
    check("jalr_word", im_wdata, 32'h0040_F809);
    wait_done();
    check("jalr_model", {31'd0, r[32]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
